// File: rtl/br_predictor_2lvl.sv
// ---------------------------------------------------------------------------
// br_predictor_2lvl
// Two-level branch direction predictor with three runtime-selectable modes:
// bimodal (PC-indexed), gshare (PC xor global history) and local two-level
// (per-PC history table xor PC). Predicts combinationally for the fetch PC and
// trains on commit. After reset the pattern history table (PHT) and local
// history table (LHT) are walked and initialised, one PHT entry per cycle.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   mode            00 bimodal, 01 gshare, 10 local, 11 bimodal
//   if_pc           fetch PC; pred_taken / pred_ghr are combinational from it
//   wb_pc, wb_ghr   committing branch PC and the GHR snapshot it carried
//   wbisbranch      commit strobe for a conditional branch
//   actual_taken    resolved direction of the committing branch
//   pred_correct    counter MSB (pre-update) at the WB index == actual_taken
//   busy            table initialisation in progress
//   br_count        committed branches, saturating
//   mispred_count   mispredicted committed branches, saturating
// ---------------------------------------------------------------------------
module br_predictor_2lvl #(
  parameter int IDX_BITS   = 8,
  parameter int GHR_BITS   = 8,
  parameter int LHT_BITS   = 4,
  parameter int LHIST_BITS = 8,
  parameter int CNT_BITS   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [15:0]         if_pc,
  output logic                pred_taken,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic [15:0]         wb_pc,
  input  logic [GHR_BITS-1:0] wb_ghr,
  input  logic                wbisbranch,
  input  logic                actual_taken,
  output logic                pred_correct,
  output logic                busy,
  output logic [15:0]         br_count,
  output logic [15:0]         mispred_count
);

  // State table
  //   ST_INIT | walking idx_ctr over the PHT/LHT, writing reset values; busy=1
  //   ST_RUN  | normal predict/train operation; busy=0

  localparam int PHT_DEPTH = 1 << IDX_BITS;
  localparam int LHT_DEPTH = 1 << LHT_BITS;

  // Weakly-not-taken: the largest counter value whose MSB is still 0.
  localparam logic [CNT_BITS-1:0] CNT_WNT  = {1'b0, {(CNT_BITS-1){1'b1}}};
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_MIN  = '0;
  localparam logic [IDX_BITS-1:0] IDX_LAST = '1;
  localparam logic [15:0]         CTR_MAX  = 16'hFFFF;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_BITS-1:0]   idx_ctr_q, idx_ctr_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [15:0]           br_count_q, br_count_d;
  logic [15:0]           mispred_count_q, mispred_count_d;

  logic [CNT_BITS-1:0]   pht_q [PHT_DEPTH];
  logic [CNT_BITS-1:0]   pht_d [PHT_DEPTH];
  logic [LHIST_BITS-1:0] lht_q [LHT_DEPTH];
  logic [LHIST_BITS-1:0] lht_d [LHT_DEPTH];

  logic [IDX_BITS-1:0]   if_pcidx, wb_pcidx;
  logic [LHT_BITS-1:0]   if_lht_idx, wb_lht_idx;
  logic [LHIST_BITS-1:0] if_hist, wb_hist;
  logic [IDX_BITS-1:0]   if_idx, wb_idx;
  logic [CNT_BITS-1:0]   if_cnt, wb_cnt;
  logic                  train;
  logic                  unused_pc_bits;

  // PC bit 0 is always zero for word-aligned instructions; high bits beyond
  // the index width do not participate in indexing.
  assign unused_pc_bits = ^{if_pc, wb_pc};

  function automatic logic [IDX_BITS-1:0] calc_idx(
    input logic [1:0]            m,
    input logic [IDX_BITS-1:0]   pcidx,
    input logic [GHR_BITS-1:0]   ghr,
    input logic [LHIST_BITS-1:0] hist
  );
    logic [IDX_BITS-1:0] idx;
    case (m)
      2'b01:   idx = pcidx ^ IDX_BITS'(ghr);
      2'b10:   idx = pcidx ^ IDX_BITS'(hist);
      default: idx = pcidx;
    endcase
    return idx;
  endfunction

  assign if_pcidx   = if_pc[IDX_BITS:1];
  assign wb_pcidx   = wb_pc[IDX_BITS:1];
  assign if_lht_idx = if_pc[LHT_BITS:1];
  assign wb_lht_idx = wb_pc[LHT_BITS:1];
  assign if_hist    = lht_q[if_lht_idx];
  assign wb_hist    = lht_q[wb_lht_idx];

  // IF indexes with the live GHR, WB with the snapshot that travelled with
  // the branch, so both sides see the history the prediction was made with.
  assign if_idx = calc_idx(mode, if_pcidx, ghr_q, if_hist);
  assign wb_idx = calc_idx(mode, wb_pcidx, wb_ghr, wb_hist);

  // Reads see the registered table only: no write-to-read bypass.
  assign if_cnt = pht_q[if_idx];
  assign wb_cnt = pht_q[wb_idx];

  assign busy          = (state_q == ST_INIT);
  assign pred_taken    = (state_q == ST_RUN) && if_cnt[CNT_BITS-1];
  assign pred_ghr      = ghr_q;
  assign pred_correct  = (wb_cnt[CNT_BITS-1] == actual_taken);
  assign br_count      = br_count_q;
  assign mispred_count = mispred_count_q;

  assign train = wbisbranch && (state_q == ST_RUN);

  always_comb begin
    state_d         = state_q;
    idx_ctr_d       = idx_ctr_q;
    ghr_d           = ghr_q;
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    pht_d           = pht_q;
    lht_d           = lht_q;

    case (state_q)
      ST_INIT: begin
        pht_d[idx_ctr_q] = CNT_WNT;
        if (int'(idx_ctr_q) < LHT_DEPTH) begin
          lht_d[idx_ctr_q[LHT_BITS-1:0]] = '0;
        end
        idx_ctr_d = idx_ctr_q + IDX_BITS'(1);
        if (idx_ctr_q == IDX_LAST) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        if (train) begin
          if (actual_taken) begin
            if (wb_cnt != CNT_MAX) begin
              pht_d[wb_idx] = wb_cnt + CNT_BITS'(1);
            end
          end else begin
            if (wb_cnt != CNT_MIN) begin
              pht_d[wb_idx] = wb_cnt - CNT_BITS'(1);
            end
          end

          // Histories advance in every mode so switching mode needs no flush.
          ghr_d             = {ghr_q[GHR_BITS-2:0], actual_taken};
          lht_d[wb_lht_idx] = {wb_hist[LHIST_BITS-2:0], actual_taken};

          if (br_count_q != CTR_MAX) begin
            br_count_d = br_count_q + 16'd1;
          end
          if (!pred_correct && (mispred_count_q != CTR_MAX)) begin
            mispred_count_d = mispred_count_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_INIT;
      idx_ctr_q       <= '0;
      ghr_q           <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_ctr_q       <= idx_ctr_d;
      ghr_q           <= ghr_d;
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  // Tables carry no reset; the INIT walk gives them defined contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pht_q <= pht_d;
      lht_q <= lht_d;
    end
  end

endmodule

// File: tb/tb_br_predictor_2lvl.sv
module tb_br_predictor_2lvl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [15:0] if_pc = 16'h0000;
  logic        pred_taken;
  logic [7:0]  pred_ghr;
  logic [15:0] wb_pc = 16'h0000;
  logic [7:0]  wb_ghr = 8'h00;
  logic        wbisbranch = 1'b0;
  logic        actual_taken = 1'b0;
  logic        pred_correct;
  logic        busy;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  int n_cmp = 0;
  int n_err = 0;

  br_predictor_2lvl dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_ghr      (pred_ghr),
    .wb_pc         (wb_pc),
    .wb_ghr        (wb_ghr),
    .wbisbranch    (wbisbranch),
    .actual_taken  (actual_taken),
    .pred_correct  (pred_correct),
    .busy          (busy),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves one posedge with rst=1, returns at negedge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts posedges until busy drops (bounded), flagging any illegal output.
  task automatic wait_init(output int cyc, output logic bad);
    cyc = 0;
    bad = 1'b0;
    #1;
    while (busy === 1'b1 && cyc < 1000) begin
      if (pred_taken !== 1'b0 || br_count !== 16'h0 || mispred_count !== 16'h0) bad = 1'b1;
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  // Called at negedge; presents a commit for one posedge, returns at next negedge.
  task automatic commit(input logic [15:0] pc, input logic [7:0] g, input logic t,
                        output logic ok);
    wb_pc        = pc;
    wb_ghr       = g;
    actual_taken = t;
    wbisbranch   = 1'b1;
    #1;
    ok = pred_correct;
    @(negedge clk);
    wbisbranch = 1'b0;
  endtask

  task automatic probe(input logic [15:0] pc);
    if_pc = pc;
    #1;
  endtask

  initial begin
    int   cyc;
    logic bad;
    logic ok;

    // ---------------- reset / INIT latency ----------------
    do_reset();
    #1;
    chk("rst_busy", busy, 1);
    chk("rst_ghr", pred_ghr, 8'h00);
    wait_init(cyc, bad);
    chk("init_cycles", cyc, 256);
    chk("init_quiet", bad, 0);

    // ---------------- bimodal saturation ----------------
    mode = 2'b00;
    probe(16'h0040);
    chk("bim_start", pred_taken, 0);
    // Same-cycle IF/WB on one entry: prediction is the pre-update value.
    wb_pc = 16'h0040; wb_ghr = 8'h00; actual_taken = 1'b1; wbisbranch = 1'b1;
    #1;
    chk("bim_nobypass", pred_taken, 0);
    chk("bim_pc1", pred_correct, 0);
    @(negedge clk);
    wbisbranch = 1'b0;
    probe(16'h0040);
    chk("bim_t1", pred_taken, 1);
    for (int i = 0; i < 3; i++) commit(16'h0040, 8'h00, 1'b1, ok);
    probe(16'h0040);
    chk("bim_t4", pred_taken, 1);
    commit(16'h0040, 8'h00, 1'b0, ok);
    probe(16'h0040);
    chk("bim_n1", pred_taken, 1);
    commit(16'h0040, 8'h00, 1'b0, ok);
    probe(16'h0040);
    chk("bim_n2", pred_taken, 0);
    chk("bim_brcnt", br_count, 6);
    chk("bim_miscnt", mispred_count, 3);
    chk("bim_ghr", pred_ghr, 8'h3C);

    // ---------------- gshare aliasing separation ----------------
    do_reset();
    wait_init(cyc, bad);
    chk("gs_init_cycles", cyc, 256);
    mode = 2'b01;
    for (int i = 0; i < 3; i++) begin
      commit(16'h0040, 8'h00, 1'b1, ok);
      commit(16'h0040, 8'h01, 1'b0, ok);
    end
    for (int i = 0; i < 8; i++) commit(16'h0200, 8'h00, 1'b0, ok);
    probe(16'h0040);
    chk("gs_ghr0", pred_ghr, 8'h00);
    chk("gs_pred_g0", pred_taken, 1);
    commit(16'h0200, 8'h00, 1'b1, ok);
    probe(16'h0040);
    chk("gs_ghr1", pred_ghr, 8'h01);
    chk("gs_pred_g1", pred_taken, 0);
    mode = 2'b00;
    #1;
    chk("gs_mode_switch", pred_taken, 1);

    // ---------------- local alternating pattern ----------------
    do_reset();
    wait_init(cyc, bad);
    mode = 2'b10;
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      commit(16'h0100, 8'h00, (k % 2) == 0, ok);
      if (k >= 24 && ok !== 1'b1) bad = 1'b1;
      if (k == 23) chk("loc_mis_k24", mispred_count, 5);
    end
    chk("loc_last16", bad, 0);
    chk("loc_mis_end", mispred_count, 5);
    chk("loc_brcnt", br_count, 40);

    // ---------------- counter saturation ----------------
    do_reset();
    wait_init(cyc, bad);
    mode = 2'b00;
    force dut.br_count_q = 16'hFFFE;
    #1;
    release dut.br_count_q;
    #1;
    chk("sat_preload", br_count, 16'hFFFE);
    @(negedge clk);
    commit(16'h0010, 8'h00, 1'b1, ok);
    chk("sat_pc_a", ok, 0);
    commit(16'h0020, 8'h00, 1'b1, ok);
    chk("sat_pc_b", ok, 0);
    commit(16'h0030, 8'h00, 1'b1, ok);
    chk("sat_pc_c", ok, 0);
    #1;
    chk("sat_brcnt", br_count, 16'hFFFF);
    chk("sat_miscnt", mispred_count, 3);

    // ---------------- reset mid-INIT with commit pulses ----------------
    do_reset();
    if_pc        = 16'h0040;
    wb_pc        = 16'h0040;
    wb_ghr       = 8'h00;
    actual_taken = 1'b1;
    wbisbranch   = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (pred_taken !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    chk("mid_first100", bad, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_busy", busy, 1);
    wait_init(cyc, bad);
    wbisbranch = 1'b0;
    chk("mid_cycles", cyc, 256);
    chk("mid_quiet", bad, 0);
    chk("mid_ghr", pred_ghr, 8'h00);
    chk("mid_brcnt", br_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
